// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants, the point_compress state encoding and the canonicalization helper.
package ed25519_pkg;

  localparam int unsigned FE_W    = 255;
  localparam int unsigned PROD_W  = 2 * FE_W;
  localparam int unsigned BIT_W   = 8;

  localparam logic [FE_W-1:0] P =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  // Inversion exponent p-2: bit 254 set, zeros only at bits 4 and 2
  localparam logic [FE_W-1:0] P_MINUS_2 =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

  localparam logic [FE_W-1:0] TWO_D =
    255'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159;

  typedef enum logic [2:0] {
    PC_IDLE,
    PC_LOAD,
    PC_SQR,
    PC_MUL,
    PC_MULX,
    PC_MULY,
    PC_FREEZE,
    PC_DONE
  } pc_state_t;

  function automatic logic [FE_W-1:0] canon(input logic [FE_W-1:0] v);
    return (v >= P) ? (v - P) : v;
  endfunction

endpackage

// File: rtl/mult_modp.sv
// Two-stage modular multiplier mod 2^255-19: full product, then two 19-folds and one conditional subtract.
module mult_modp
  import ed25519_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [FE_W-1:0] a,
  input  logic [FE_W-1:0] b,
  output logic [FE_W-1:0] r,
  output logic            dr
);

  localparam int unsigned F1_W = FE_W + 5;
  localparam int unsigned F2_W = FE_W + 1;

  logic [PROD_W-1:0] r_prod;
  logic              r_prod_vld;
  logic [FE_W-1:0]   r_res;
  logic              r_dr;
  logic [F1_W-1:0]   w_fold1;
  logic [F2_W-1:0]   w_fold2;
  logic [F2_W-1:0]   w_red;

  // 2^255 == 19 (mod p): fold the high half twice, result lands below 2p
  always_comb begin
    w_fold1 = F1_W'(r_prod[FE_W-1:0]) + F1_W'(r_prod[PROD_W-1:FE_W]) * F1_W'(19);
    w_fold2 = F2_W'(w_fold1[FE_W-1:0]) + F2_W'(w_fold1[F1_W-1:FE_W]) * F2_W'(19);
    w_red   = (w_fold2 >= F2_W'(P)) ? (w_fold2 - F2_W'(P)) : w_fold2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_res      <= '0;
      r_dr       <= 1'b0;
    end else begin
      r_prod_vld <= en;
      r_dr       <= r_prod_vld;
      if (en) begin
        r_prod <= PROD_W'(a) * PROD_W'(b);
      end
      if (r_prod_vld) begin
        r_res <= FE_W'(w_red);
      end
    end
  end

  assign r  = r_res;
  assign dr = r_dr;

endmodule

// File: rtl/point_compress.sv
// Projective (X:Y:Z) to compressed Ed25519 encoding via Z^(p-2) on one shared multiplier.
module point_compress
  import ed25519_pkg::*;
#(
  parameter int unsigned N = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] x_aff,
  output logic [N-1:0] y_aff,
  output logic [N:0]   enc,
  output logic         data_rdy,
  output logic         busy,
  output logic         err
);

  pc_state_t        r_state;
  pc_state_t        w_state_nxt;
  logic [N-1:0]     r_x;
  logic [N-1:0]     r_y;
  logic [N-1:0]     r_z;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_xa;
  logic [N-1:0]     r_ya;
  logic [BIT_W-1:0] r_bit;
  logic             r_mul_busy;
  logic [N-1:0]     r_x_aff;
  logic [N-1:0]     r_y_aff;
  logic             r_data_rdy;
  logic             r_busy;
  logic             r_err;

  logic             w_accept;
  logic             w_z_bad;
  logic             w_is_mul;
  logic             w_mul_en;
  logic [N-1:0]     w_mul_a;
  logic [N-1:0]     w_mul_b;
  logic [N-1:0]     w_mul_r;
  logic             w_mul_dr;
  logic             w_e_bit;
  logic             w_acc_ld_z;
  logic             w_acc_we;
  logic             w_bit_dec;
  logic             w_xa_we;
  logic             w_ya_we;

  assign w_accept = (r_state == PC_IDLE) && en;
  assign w_z_bad  = (r_z == '0) || (r_z == P);
  assign w_is_mul = (r_state == PC_SQR) || (r_state == PC_MUL) ||
                    (r_state == PC_MULX) || (r_state == PC_MULY);
  assign w_mul_en = w_is_mul && !r_mul_busy;
  assign w_e_bit  = P_MINUS_2[r_bit];

  // Operand select: square (acc,acc), multiply (acc,z), affine (x|y,acc)
  assign w_mul_a = (r_state == PC_MULX) ? r_x :
                   (r_state == PC_MULY) ? r_y : r_acc;
  assign w_mul_b = (r_state == PC_MUL) ? r_z : r_acc;

  mult_modp u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_mul_en),
    .a     (w_mul_a),
    .b     (w_mul_b),
    .r     (w_mul_r),
    .dr    (w_mul_dr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= PC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_ld_z  = 1'b0;
    w_acc_we    = 1'b0;
    w_bit_dec   = 1'b0;
    w_xa_we     = 1'b0;
    w_ya_we     = 1'b0;
    case (r_state)
      PC_IDLE: begin
        if (en) w_state_nxt = PC_LOAD;
      end
      PC_LOAD: begin
        // Degenerate Z goes through FREEZE so the outputs are cleared before DONE
        if (w_z_bad) begin
          w_state_nxt = PC_FREEZE;
        end else begin
          w_acc_ld_z  = 1'b1;
          w_state_nxt = PC_SQR;
        end
      end
      PC_SQR: begin
        if (w_mul_dr) begin
          w_acc_we = 1'b1;
          if (w_e_bit) begin
            w_state_nxt = PC_MUL;
          end else if (r_bit == '0) begin
            w_state_nxt = PC_MULX;
          end else begin
            w_bit_dec   = 1'b1;
            w_state_nxt = PC_SQR;
          end
        end
      end
      PC_MUL: begin
        if (w_mul_dr) begin
          w_acc_we = 1'b1;
          if (r_bit == '0) begin
            w_state_nxt = PC_MULX;
          end else begin
            w_bit_dec   = 1'b1;
            w_state_nxt = PC_SQR;
          end
        end
      end
      PC_MULX: begin
        if (w_mul_dr) begin
          w_xa_we     = 1'b1;
          w_state_nxt = PC_MULY;
        end
      end
      PC_MULY: begin
        if (w_mul_dr) begin
          w_ya_we     = 1'b1;
          w_state_nxt = PC_FREEZE;
        end
      end
      PC_FREEZE: w_state_nxt = PC_DONE;
      PC_DONE:   w_state_nxt = PC_IDLE;
      default:   w_state_nxt = PC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_acc      <= '0;
      r_xa       <= '0;
      r_ya       <= '0;
      r_bit      <= '0;
      r_mul_busy <= 1'b0;
      r_x_aff    <= '0;
      r_y_aff    <= '0;
      r_data_rdy <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_data_rdy <= (w_state_nxt == PC_DONE);
      r_busy     <= (w_state_nxt != PC_IDLE);

      if (w_accept) begin
        r_x   <= x;
        r_y   <= y;
        r_z   <= z;
        r_err <= 1'b0;
      end else if (w_state_nxt == PC_DONE) begin
        r_err <= w_z_bad;
      end

      // Operands stay put between the enable pulse and dr
      if (w_mul_dr) begin
        r_mul_busy <= 1'b0;
      end else if (w_mul_en) begin
        r_mul_busy <= 1'b1;
      end

      if (w_acc_ld_z) begin
        r_acc <= r_z;
        r_bit <= BIT_W'(FE_W - 2);
      end else begin
        if (w_acc_we) r_acc <= w_mul_r;
        if (w_bit_dec) r_bit <= r_bit - BIT_W'(1);
      end

      if (w_xa_we) r_xa <= w_mul_r;
      if (w_ya_we) r_ya <= w_mul_r;

      if (r_state == PC_FREEZE) begin
        r_x_aff <= w_z_bad ? '0 : canon(r_xa);
        r_y_aff <= w_z_bad ? '0 : canon(r_ya);
      end
    end
  end

  assign x_aff    = r_x_aff;
  assign y_aff    = r_y_aff;
  assign enc      = {r_x_aff[0], r_y_aff};
  assign data_rdy = r_data_rdy;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
